// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters must hold the value DEPTH itself.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: IMEM request/response, decoder handshake, redirect.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] iaddr;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            fetch_err;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, iaddr, fetch_err,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready,
           redirect, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, iaddr, fetch_err,
    output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready,
           redirect, redirect_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; callers guarantee no overflow/underflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [W-1:0]                  wdata,
  input  logic                          pop,
  output logic [W-1:0]                  rdata,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited IMEM requests, in-order
// response buffering and redirect with wrong-path response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  fif
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   pend_cnt;
  logic [CW-1:0]   pend_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   pq_cnt;
  logic            fetch_err_q;
  logic            credit;
  logic            fire;
  logic            rsp;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            head_valid;
  logic            deq;
  logic [XLEN-1:0] pq_head;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Outstanding plus buffered never exceeds DEPTH, so every response has a slot.
  assign credit = ({1'b0, pend_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);
  assign fif.imem_req_valid = reset && !fetch_err_q && !fif.redirect && credit;
  assign fif.imem_addr      = pc;
  assign fire = fif.imem_req_valid && fif.imem_req_ready;

  // Responses with nothing outstanding (e.g. straight after reset) are ignored.
  assign rsp      = fif.imem_rsp_valid && (pend_cnt != '0);
  assign rsp_drop = rsp && ((drop_cnt != '0) || fif.redirect);
  assign rsp_keep = rsp && !rsp_drop;
  assign pend_nxt = pend_cnt + CW'(fire) - CW'(rsp);

  assign head_valid = reset && (fifo_cnt != '0);
  assign deq        = head_valid && fif.instr_ready;

  assign push_entry.addr  = pq_head;
  assign push_entry.instr = fif.imem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      pend_cnt    <= '0;
      drop_cnt    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      pend_cnt <= pend_nxt;
      if (fif.redirect) begin
        pc          <= fif.redirect_target & 32'hFFFF_FFFE;
        drop_cnt    <= pend_nxt;
        fetch_err_q <= fif.redirect_target[1];
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (fif.redirect),
    .push  (rsp_keep),
    .wdata (push_entry),
    .pop   (deq),
    .rdata (head),
    .count (fifo_cnt)
  );

  // Addresses of in-flight right-path requests, popped as their words return.
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pend (
    .clk   (clk),
    .reset (reset),
    .flush (fif.redirect),
    .push  (fire),
    .wdata (pc),
    .pop   (rsp_keep),
    .rdata (pq_head),
    .count (pq_cnt)
  );

  assign fif.instr_valid = head_valid;
  assign fif.instr       = head_valid ? head.instr : NOP;
  assign fif.iaddr       = head_valid ? head.addr : '0;
  assign fif.fetch_err   = fetch_err_q;

  a_rsp_credit : assert property (@(posedge clk) disable iff (!reset)
    fif.imem_rsp_valid |-> (pend_cnt != '0))
    else $error("imem response without an outstanding request");

  a_pq_nonempty : assert property (@(posedge clk) disable iff (!reset)
    rsp_keep |-> (pq_cnt != '0))
    else $error("kept response with empty pending-address queue");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order IMEM model (IMEM word = ~addr).
module tb_fetch_unit;

  logic clk;
  logic reset;
  fetch_if fif ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .NOP(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_deq = 0;
  int          n_fire = 0;
  int          cyc = 0;
  int          fix_lat = 1;
  bit          rand_mode = 0;
  bit          stab_en = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    exp_pc = 32'h0000_0000;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  // IMEM model: records fires at negedge, returns words in order after the latency.
  initial begin
    fif.imem_req_ready = 1'b1;
    fif.imem_rsp_valid = 1'b0;
    fif.imem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (stab_en && prev_stall && fif.imem_req_valid)
          check("addr_stable", fif.imem_addr, prev_addr);
        prev_stall = fif.imem_req_valid && !fif.imem_req_ready;
        prev_addr  = fif.imem_addr;
        if (fif.imem_req_valid && fif.imem_req_ready) begin
          q.push_back('{fif.imem_addr,
                        cyc + (rand_mode ? int'($urandom_range(1, 4)) : fix_lat)});
          n_fire++;
        end
      end
      @(posedge clk);
      #2;
      cyc++;
      if (q.size() > 0 && q[0].due <= cyc) begin
        fif.imem_rsp_valid = 1'b1;
        fif.imem_rdata     = ~q[0].addr;
        void'(q.pop_front());
      end else begin
        fif.imem_rsp_valid = 1'b0;
      end
      fif.imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Every consumed instruction must be the next sequential one on the current path.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && fif.instr_valid && fif.instr_ready) begin
        check("iaddr", fif.iaddr, exp_pc);
        check("instr", fif.instr, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_deq++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int f0;
    reset               = 1'b0;
    fif.instr_ready     = 1'b1;
    fif.redirect        = 1'b0;
    fif.redirect_target = '0;

    // Reset values
    cycle();
    cycle();
    sample();
    check("rst_req_valid", 32'(fif.imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(fif.instr_valid), 32'd0);
    check("rst_instr", fif.instr, 32'h0000_0013);
    check("rst_iaddr", fif.iaddr, 32'd0);
    check("rst_fetch_err", 32'(fif.fetch_err), 32'd0);

    // Release: addresses 0,4 then first word 2 cycles after first fire
    cycle();
    reset  = 1'b1;
    exp_pc = 32'h0;
    sample();
    check("c0_req_valid", 32'(fif.imem_req_valid), 32'd1);
    check("c0_addr", fif.imem_addr, 32'h0);
    check("c0_ivalid", 32'(fif.instr_valid), 32'd0);
    cycle();
    sample();
    check("c1_addr", fif.imem_addr, 32'h4);
    check("c1_ivalid", 32'(fif.instr_valid), 32'd0);
    cycle();
    sample();
    check("c2_ivalid", 32'(fif.instr_valid), 32'd1);
    check("c2_iaddr", fif.iaddr, 32'h0);
    b = n_deq;
    repeat (20) cycle();
    check("t1_progress", 32'(n_deq - b >= 10), 32'd1);

    // Decoder stall: exactly two requests, then requests stop with both words held
    fif.instr_ready = 1'b0;
    do_reset();
    f0 = n_fire;
    repeat (10) cycle();
    sample();
    check("stall_fires", 32'(n_fire - f0), 32'd2);
    check("stall_req_valid", 32'(fif.imem_req_valid), 32'd0);
    check("stall_ivalid", 32'(fif.instr_valid), 32'd1);
    check("stall_iaddr", fif.iaddr, 32'h0);
    cycle();
    fif.instr_ready = 1'b1;
    b = n_deq;
    repeat (10) cycle();
    check("stall_release", 32'(n_deq - b >= 3), 32'd1);

    // Redirect to 0x100 with two requests outstanding
    fix_lat = 3;
    do_reset();
    cycle();
    cycle();
    fif.redirect        = 1'b1;
    fif.redirect_target = 32'h0000_0100;
    sample();
    check("rd_pending", 32'(q.size()), 32'd2);
    check("rd_req_valid", 32'(fif.imem_req_valid), 32'd0);
    cycle();
    fif.redirect = 1'b0;
    exp_pc       = 32'h0000_0100;
    b = n_deq;
    repeat (15) cycle();
    check("rd_progress", 32'(n_deq - b >= 3), 32'd1);

    // JALR-style target with bit 0 set
    fix_lat = 1;
    repeat (6) cycle();
    fif.redirect        = 1'b1;
    fif.redirect_target = 32'h0000_0205;
    sample();
    check("jalr_rd_req", 32'(fif.imem_req_valid), 32'd0);
    cycle();
    fif.redirect = 1'b0;
    exp_pc       = 32'h0000_0204;
    sample();
    check("jalr_req_valid", 32'(fif.imem_req_valid), 32'd1);
    check("jalr_addr", fif.imem_addr, 32'h0000_0204);
    repeat (10) cycle();

    // Misaligned target: sticky error, no issue, nothing delivered
    fif.redirect        = 1'b1;
    fif.redirect_target = 32'h0000_0206;
    cycle();
    fif.redirect = 1'b0;
    exp_pc       = 32'hFFFF_FFF0;
    sample();
    check("err_set", 32'(fif.fetch_err), 32'd1);
    check("err_req_valid", 32'(fif.imem_req_valid), 32'd0);
    repeat (5) cycle();
    sample();
    check("err_hold", 32'(fif.fetch_err), 32'd1);
    check("err_req_valid2", 32'(fif.imem_req_valid), 32'd0);
    check("err_ivalid", 32'(fif.instr_valid), 32'd0);
    cycle();
    fif.redirect        = 1'b1;
    fif.redirect_target = 32'h0000_0300;
    cycle();
    fif.redirect = 1'b0;
    exp_pc       = 32'h0000_0300;
    sample();
    check("err_clear", 32'(fif.fetch_err), 32'd0);
    check("clr_req_valid", 32'(fif.imem_req_valid), 32'd1);
    check("clr_addr", fif.imem_addr, 32'h0000_0300);
    b = n_deq;
    repeat (10) cycle();
    check("clr_progress", 32'(n_deq - b >= 3), 32'd1);

    // PC wrap-around past 0xFFFF_FFFC
    fif.redirect        = 1'b1;
    fif.redirect_target = 32'hFFFF_FFF8;
    cycle();
    fif.redirect = 1'b0;
    exp_pc       = 32'hFFFF_FFF8;
    b = n_deq;
    repeat (12) cycle();
    sample();
    check("wrap_err", 32'(fif.fetch_err), 32'd0);
    check("wrap_progress", 32'(n_deq - b >= 5), 32'd1);
    cycle();

    // Random IMEM ready/latency and decoder ready over 1000 instructions
    rand_mode = 1'b1;
    stab_en   = 1'b1;
    b = n_deq;
    for (int i = 0; i < 20000 && (n_deq - b) < 1000; i++) begin
      fif.instr_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check("rand_count", 32'(n_deq - b >= 1000), 32'd1);
    rand_mode       = 1'b0;
    stab_en         = 1'b0;
    fif.instr_ready = 1'b1;

    // Reset mid-stream with two requests outstanding
    fix_lat = 3;
    repeat (6) cycle();
    for (int i = 0; i < 50; i++) begin
      sample();
      if (q.size() == 2) break;
      cycle();
    end
    check("mid_pending", 32'(q.size()), 32'd2);
    cycle();
    reset  = 1'b0;
    exp_pc = 32'h0000_0000;
    cycle();
    reset = 1'b1;
    sample();
    check("mid_req_valid", 32'(fif.imem_req_valid), 32'd1);
    check("mid_addr", fif.imem_addr, 32'h0);
    check("mid_ivalid", 32'(fif.instr_valid), 32'd0);
    check("mid_instr", fif.instr, 32'h0000_0013);
    check("mid_iaddr", fif.iaddr, 32'h0);
    check("mid_fetch_err", 32'(fif.fetch_err), 32'd0);
    b = n_deq;
    repeat (15) cycle();
    check("mid_restart", 32'(n_deq - b >= 3), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
